// File: rtl/ecc_pkg.sv
// Shared ECC-core constants: moddiv FSM encoding, default width, secp256k1 field prime and group order.
package ecc_pkg;

    localparam int DEF_WIDTH = 256;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [255:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] SECP256K1_N =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

    // Worst-case step count of the binary extended Euclid loop for a w-bit modulus.
    function automatic int moddiv_max_it(input int w);
        return 4 * w + 4;
    endfunction

endpackage

// File: rtl/moddiv_half.sv
// Halving modulo an odd m: y = x/2 mod m, i.e. x even ? x>>1 : (x+m)>>1 with a carry-safe sum.
module moddiv_half #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] y
);
    logic [WIDTH:0] sum;

    assign sum = {1'b0, x} + {1'b0, m};
    assign y   = x[0] ? WIDTH'(sum >> 1) : (x >> 1);

endmodule

// File: rtl/moddiv.sv
// Modular divider c = b * a^-1 mod m (odd m), binary extended Euclid, one step per clock.
// Define MODDIV_CONST_TIME_EN for fixed latency (RUN always MAX_IT clocks, no timeout error).
module moddiv
    import ecc_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int MAX_IT = moddiv_max_it(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] c,
    output logic             ready,
    output logic             busy,
    output logic             err
);
    localparam int               CNT_W = $clog2(MAX_IT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(MAX_IT - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] THREE = WIDTH'(3);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] u, v, x1, x2, mr;
    logic [WIDTH-1:0] u_n, v_n, x1_n, x2_n;
    logic [WIDTH-1:0] x1_half, x2_half, x1_sub, x2_sub;
    logic [WIDTH-1:0] fin_c;
    logic             fin, fin_err, load_bad;
`ifdef MODDIV_CONST_TIME_EN
    logic             frz;
`endif

    assign ready = (state == ST_DONE);
    assign busy  = (state == ST_LOAD) || (state == ST_RUN);

    moddiv_half #(.WIDTH(WIDTH)) u_half1 (.x(x1), .m(mr), .y(x1_half));
    moddiv_half #(.WIDTH(WIDTH)) u_half2 (.x(x2), .m(mr), .y(x2_half));

    // Both x operands are already in [0,m), so a single conditional +m restores the range.
    assign x1_sub = x1 - x2 + ((x1 < x2) ? mr : '0);
    assign x2_sub = x2 - x1 + ((x2 < x1) ? mr : '0);

    // In LOAD, u still holds a and x1 still holds b.
    assign load_bad = !mr[0] || (mr < THREE) || (u >= mr) || (x1 >= mr) || (u == '0);

    always_comb begin
        fin     = 1'b1;
        fin_err = 1'b0;
        fin_c   = '0;
        u_n     = u;
        v_n     = v;
        x1_n    = x1;
        x2_n    = x2;
        if (u == ONE) begin
            fin_c = x1;
        end else if (v == ONE) begin
            fin_c = x2;
        end else if ((u == '0) || (v == '0)) begin
            fin_err = 1'b1;
        end else begin
            fin = 1'b0;
            if (!u[0]) begin
                u_n  = u >> 1;
                x1_n = x1_half;
            end else if (!v[0]) begin
                v_n  = v >> 1;
                x2_n = x2_half;
            end else if (u >= v) begin
                u_n  = u - v;
                x1_n = x1_sub;
            end else begin
                v_n  = v - u;
                x2_n = x2_sub;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            c     <= '0;
            err   <= 1'b0;
            u     <= '0;
            v     <= '0;
            x1    <= '0;
            x2    <= '0;
            mr    <= '0;
`ifdef MODDIV_CONST_TIME_EN
            frz   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        u     <= a;
                        x1    <= b;
                        mr    <= m;
                        c     <= '0;
                        err   <= 1'b0;
                        cnt   <= '0;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    v   <= mr;
                    x2  <= '0;
                    cnt <= '0;
`ifdef MODDIV_CONST_TIME_EN
                    // Illegal inputs still run the full RUN window so timing leaks nothing.
                    frz   <= load_bad;
                    err   <= load_bad;
                    state <= ST_RUN;
`else
                    if (load_bad) begin
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_RUN;
                    end
`endif
                end
                ST_RUN: begin
                    cnt <= cnt + 1'b1;
`ifdef MODDIV_CONST_TIME_EN
                    if (!frz) begin
                        if (fin) begin
                            frz <= 1'b1;
                            c   <= fin_c;
                            err <= fin_err;
                        end else begin
                            u  <= u_n;
                            v  <= v_n;
                            x1 <= x1_n;
                            x2 <= x2_n;
                        end
                    end
                    if (cnt == LAST) state <= ST_DONE;
`else
                    if (fin) begin
                        c     <= fin_c;
                        err   <= fin_err;
                        state <= ST_DONE;
                    end else if (cnt == LAST) begin
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        u  <= u_n;
                        v  <= v_n;
                        x1 <= x1_n;
                        x2 <= x2_n;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_moddiv.sv
// Directed bench for moddiv: 8-bit vector table, multi-cycle corner sequences, 256-bit secp256k1 checks.
module tb_moddiv;
    import ecc_pkg::*;

    localparam int LAT8   = moddiv_max_it(8) + 3;
    localparam int LAT256 = moddiv_max_it(256) + 3;

    typedef struct {
        logic [7:0] m;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, m8 = '0;
    logic [7:0] c8;
    logic       rdy8, bsy8, err8;

    logic         start2 = 1'b0;
    logic [255:0] a2 = '0, b2 = '0, m2 = '0;
    logic [255:0] c2;
    logic         rdy2, bsy2, err2;

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    moddiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .b(b8), .a(a8), .m(m8),
        .c(c8), .ready(rdy8), .busy(bsy8), .err(err8)
    );

    moddiv #(.WIDTH(256)) dut256 (
        .clk(clk), .rst(rst), .start(start2), .b(b2), .a(a2), .m(m2),
        .c(c2), .ready(rdy2), .busy(bsy2), .err(err2)
    );

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // lat counts clock cycles from the one carrying start through the first one showing ready.
    task automatic run8(input string nm, input logic [7:0] mm, input logic [7:0] aa,
                        input logic [7:0] bb, output logic [7:0] rc, output logic re,
                        output int lat);
        @(negedge clk);
        m8 = mm; a8 = aa; b8 = bb; start8 = 1'b1;
        lat = 1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat++;
        chk({nm, "_acc_busy"}, 256'(bsy8), 256'(1));
        chk({nm, "_acc_ready"}, 256'(rdy8), 256'(0));
        while (!rdy8 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_timeout"}, 256'(rdy8), 256'(1));
        rc = c8;
        re = err8;
    endtask

    task automatic run256(input string nm, input logic [255:0] mm, input logic [255:0] aa,
                          input logic [255:0] bb, output logic [255:0] rc, output logic re,
                          output int lat);
        @(negedge clk);
        m2 = mm; a2 = aa; b2 = bb; start2 = 1'b1;
        lat = 1;
        @(posedge clk); #1;
        start2 = 1'b0;
        lat++;
        while (!rdy2 && lat < 1200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_timeout"}, 256'(rdy2), 256'(1));
        rc = c2;
        re = err2;
    endtask

    initial begin
        vec_t         tv[17];
        logic [7:0]   rc;
        logic         re;
        int           lat, lat_a;
        logic [255:0] rc2;
        logic [511:0] prod;
        int           primes[4];

        tv[0]  = '{m: 8'd13,  a: 8'd3,   b: 8'd1,   c: 8'd9,   e: 1'b0};
        tv[1]  = '{m: 8'd13,  a: 8'd3,   b: 8'd5,   c: 8'd6,   e: 1'b0};
        tv[2]  = '{m: 8'd13,  a: 8'd1,   b: 8'd7,   c: 8'd7,   e: 1'b0};
        tv[3]  = '{m: 8'd13,  a: 8'd2,   b: 8'd1,   c: 8'd7,   e: 1'b0};
        tv[4]  = '{m: 8'd13,  a: 8'd12,  b: 8'd1,   c: 8'd12,  e: 1'b0};
        tv[5]  = '{m: 8'd251, a: 8'd2,   b: 8'd1,   c: 8'd126, e: 1'b0};
        tv[6]  = '{m: 8'd255, a: 8'd2,   b: 8'd3,   c: 8'd129, e: 1'b0};
        tv[7]  = '{m: 8'd255, a: 8'd254, b: 8'd254, c: 8'd1,   e: 1'b0};
        tv[8]  = '{m: 8'd3,   a: 8'd2,   b: 8'd2,   c: 8'd1,   e: 1'b0};
        tv[9]  = '{m: 8'd13,  a: 8'd5,   b: 8'd0,   c: 8'd0,   e: 1'b0};
        tv[10] = '{m: 8'd251, a: 8'd250, b: 8'd1,   c: 8'd250, e: 1'b0};
        tv[11] = '{m: 8'd12,  a: 8'd5,   b: 8'd1,   c: 8'd0,   e: 1'b1};
        tv[12] = '{m: 8'd13,  a: 8'd0,   b: 8'd1,   c: 8'd0,   e: 1'b1};
        tv[13] = '{m: 8'd13,  a: 8'd13,  b: 8'd1,   c: 8'd0,   e: 1'b1};
        tv[14] = '{m: 8'd9,   a: 8'd6,   b: 8'd1,   c: 8'd0,   e: 1'b1};
        tv[15] = '{m: 8'd13,  a: 8'd3,   b: 8'd13,  c: 8'd0,   e: 1'b1};
        tv[16] = '{m: 8'd255, a: 8'd5,   b: 8'd1,   c: 8'd0,   e: 1'b1};
        primes = '{3, 13, 97, 251};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_c", 256'(c8), 256'(0));
        chk("rst_ready", 256'(rdy8), 256'(0));
        chk("rst_busy", 256'(bsy8), 256'(0));
        chk("rst_err", 256'(err8), 256'(0));
        chk("rst_ready256", 256'(rdy2), 256'(0));
        rst = 1'b0;

        // Vector table, back-to-back starts from DONE
        foreach (tv[i]) begin
            run8($sformatf("vec%0d", i), tv[i].m, tv[i].a, tv[i].b, rc, re, lat);
            chk($sformatf("vec%0d_c", i), 256'(rc), 256'(tv[i].c));
            chk($sformatf("vec%0d_err", i), 256'(re), 256'(tv[i].e));
            chk($sformatf("vec%0d_lat", i), 256'(lat <= LAT8), 256'(1));
        end

        // Result and ready held in DONE while start stays low
        repeat (3) @(posedge clk);
        #1;
        chk("hold_ready", 256'(rdy8), 256'(1));
        chk("hold_c", 256'(c8), 256'(8'd0));

        // Reset two clocks into RUN aborts without a ready pulse
        @(negedge clk);
        m8 = 8'd13; a8 = 8'd3; b8 = 8'd1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t4_busy_before", 256'(bsy8), 256'(1));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t4_ready", 256'(rdy8), 256'(0));
        chk("t4_busy", 256'(bsy8), 256'(0));
        chk("t4_c", 256'(c8), 256'(0));
        rst = 1'b0;
        run8("t4_fresh", 8'd13, 8'd3, 8'd1, rc, re, lat);
        chk("t4_fresh_c", 256'(rc), 256'(9));

        // start while busy with other operands is dropped
        @(negedge clk);
        m8 = 8'd13; a8 = 8'd3; b8 = 8'd1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        @(negedge clk);
        m8 = 8'd251; a8 = 8'd2; b8 = 8'd5; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0;
        while (!rdy8 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("t5_timeout", 256'(rdy8), 256'(1));
        chk("t5_c", 256'(c8), 256'(9));
        chk("t5_err", 256'(err8), 256'(0));

        // Latency independence of the operand
        run8("t6a", 8'd13, 8'd1, 8'd1, rc, re, lat_a);
        chk("t6a_c", 256'(rc), 256'(1));
        run8("t6b", 8'd13, 8'd7, 8'd1, rc, re, lat);
        chk("t6b_c", 256'(rc), 256'(2));
`ifdef MODDIV_CONST_TIME_EN
        chk("t6a_lat", 256'(lat_a), 256'(LAT8));
        chk("t6b_lat", 256'(lat), 256'(LAT8));
`else
        chk("t6a_lat", 256'(lat_a <= LAT8), 256'(1));
        chk("t6b_lat", 256'(lat <= LAT8), 256'(1));
`endif

        // Random prime moduli against a brute-force inverse search
        for (int k = 0; k < 120; k++) begin
            int mm, aa, bb, ex;
            mm = primes[$urandom_range(0, 3)];
            aa = $urandom_range(1, mm - 1);
            bb = $urandom_range(0, mm - 1);
            ex = 0;
            for (int x = 0; x < mm; x++)
                if ((x * aa) % mm == bb) ex = x;
            run8($sformatf("rnd%0d", k), 8'(mm), 8'(aa), 8'(bb), rc, re, lat);
            chk($sformatf("rnd%0d_c m=%0d a=%0d b=%0d", k, mm, aa, bb), 256'(rc), 256'(ex));
            chk($sformatf("rnd%0d_err", k), 256'(re), 256'(0));
            chk($sformatf("rnd%0d_lat", k), 256'(lat <= LAT8), 256'(1));
        end

        // 256-bit on secp256k1 p: c*a == b (mod p)
        run256("t1", SECP256K1_P,
               256'h8a85638b_5e1d3c77_04a9f2e1_6b3c9d58_a7e4f021_3d6c8b95_1f0e7a42_27fc13c9,
               256'hfed5b7e8_3a91c4d2_6e0f5b87_c2d4a139_5b7e8f01_9c3a6d24_e8b1f750_0791219a,
               rc2, re, lat);
        prod = 512'(rc2) * 512'(a2);
        chk("t1_prod", 256'(prod % 512'(SECP256K1_P)), b2);
        chk("t1_range", 256'(rc2 < SECP256K1_P), 256'(1));
        chk("t1_err", 256'(re), 256'(0));
        chk("t1_lat", 256'(lat <= LAT256), 256'(1));

        // Half of one mod p is (p+1)/2
        run256("t1_half", SECP256K1_P, 256'd2, 256'd1, rc2, re, lat);
        chk("t1_half_c", rc2, 256'((257'(SECP256K1_P) + 257'd1) >> 1));
        chk("t1_half_err", 256'(re), 256'(0));

        // ECDSA-style inverse on the group order n
        run256("t1n", SECP256K1_N,
               256'h3b1f6d2a_9c04e8b7_51a6f3d0_7e2c94b1_0d8f5a63_c7e1b429_6a3d0f8e_b5c27419,
               256'd1, rc2, re, lat);
        prod = 512'(rc2) * 512'(a2);
        chk("t1n_prod", 256'(prod % 512'(SECP256K1_N)), 256'd1);
        chk("t1n_err", 256'(re), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
